// File: rtl/sample_dumper_pkg.sv
// Shared constants for the SDRAM sample dumper: state encodings, sync-byte
// defaults, memory geometry and the header byte selector.
// No ports; imported by the interface, the byte sender and the top.
package sample_dumper_pkg;

  localparam int unsigned SDRAM_WORDS = 8388608;
  localparam int unsigned ADDR_W      = $clog2(SDRAM_WORDS);
  localparam logic [7:0]  HDR0_DEF    = 8'hA5;
  localparam logic [7:0]  HDR1_DEF    = 8'h5A;
  localparam int unsigned HDR_BYTES   = 5;
  localparam int unsigned WORD_BYTES  = 4;

  // Main FSM uses IDLE/HDR/RD_REQ/RD_WAIT/TX_LOAD/NEXT/FINISH; the byte
  // sender walks IDLE/TX_LOAD/TX_GUARD/TX_WAIT.
  typedef enum logic [3:0] {
    IDLE, HDR, RD_REQ, RD_WAIT, TX_LOAD, TX_GUARD, TX_WAIT, NEXT, FINISH
  } state_t;

  // Header: two sync bytes, then the 23-bit last address MSB-first with
  // the top byte zero-padded.
  function automatic logic [7:0] hdr_byte(input logic [2:0]        idx,
                                          input logic [7:0]        h0,
                                          input logic [7:0]        h1,
                                          input logic [ADDR_W-1:0] last);
    case (idx)
      3'd0:    hdr_byte = h0;
      3'd1:    hdr_byte = h1;
      3'd2:    hdr_byte = {1'b0, last[22:16]};
      3'd3:    hdr_byte = last[15:8];
      default: hdr_byte = last[7:0];
    endcase
  endfunction

endpackage

// File: rtl/sample_dumper_if.sv
// SDRAM command/read-data and UART byte channels of the dumper.
// master = dumper side (drives cmd_* and tx_*), slave = SDRAM controller + UART.
// Ports: cmd_enable/cmd_wr/cmd_address/cmd_ready, data_out/data_out_ready, tx_byte/tx_en/tx_ready.
interface sample_dumper_if;
  import sample_dumper_pkg::*;

  logic              cmd_enable;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_address;
  logic              cmd_ready;
  logic [31:0]       data_out;
  logic              data_out_ready;
  logic [7:0]        tx_byte;
  logic              tx_en;
  logic              tx_ready;

  modport master (
    output cmd_enable, cmd_wr, cmd_address, tx_byte, tx_en,
    input  cmd_ready, data_out, data_out_ready, tx_ready
  );

  modport slave (
    input  cmd_enable, cmd_wr, cmd_address, tx_byte, tx_en,
    output cmd_ready, data_out, data_out_ready, tx_ready
  );

endinterface

// File: rtl/sample_dumper_byte_sender.sv
// Byte sender: takes one byte on a load pulse and runs the UART strobe handshake.
// Latency: tx_en one cycle after tx_ready seen; ack pulses once UART is idle again.
// Backpressure: holds the byte until tx_ready=1; loads are only issued after ack.
// Ports: clk100, rst_p, ld_i/byte_i/ack_o (to FSM), tx_ready_i/tx_byte_o/tx_en_o (to UART).
module byte_sender
  import sample_dumper_pkg::*;
(
  input  logic       clk100,
  input  logic       rst_p,
  input  logic       ld_i,
  input  logic [7:0] byte_i,
  output logic       ack_o,
  input  logic       tx_ready_i,
  output logic [7:0] tx_byte_o,
  output logic       tx_en_o
);

  state_t     state_q;
  logic [7:0] tx_byte_q;
  logic       tx_en_q;
  logic       ack_q;

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      state_q   <= IDLE;
      tx_byte_q <= 8'h00;
      tx_en_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: if (ld_i) begin
          tx_byte_q <= byte_i;
          state_q   <= TX_LOAD;
        end
        TX_LOAD: if (tx_ready_i) begin
          tx_en_q <= 1'b1;
          state_q <= TX_GUARD;
        end
        // UART takes a cycle to drop tx_ready after the strobe; don't trust it here.
        TX_GUARD: begin
          tx_en_q <= 1'b0;
          state_q <= TX_WAIT;
        end
        TX_WAIT: if (tx_ready_i) begin
          ack_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          tx_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_byte_o = tx_byte_q;
  assign tx_en_o   = tx_en_q;
  assign ack_o     = ack_q;

endmodule

// File: rtl/sample_dumper.sv
// Dumps SDRAM words 0..last_addr over the UART behind a 5-byte header.
// Latency: busy the cycle after start; one read in flight, 4 bytes sent per word.
// Backpressure: waits on cmd_ready, data_out_ready (with timeout) and tx_ready.
// Ports: clk100, rst_p, start, abort, last_addr, busy, done, error, bus (sample_dumper_if.master).
module sample_dumper
  import sample_dumper_pkg::*;
#(
  parameter logic [7:0]  HDR0       = HDR0_DEF,
  parameter logic [7:0]  HDR1       = HDR1_DEF,
  parameter int unsigned RD_TIMEOUT = 1023
) (
  input  logic              clk100,
  input  logic              rst_p,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  sample_dumper_if.master   bus
);

  localparam int unsigned     TW   = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMAX = TW'(RD_TIMEOUT - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, last_q, cmd_address_q;
  logic              cmd_enable_q, busy_q, done_q, error_q;
  logic              abort_seen_q, wait_ack_q, ld_q;
  logic [2:0]        idx_q;
  logic [7:0]        ld_byte_q;
  logic [31:0]       shift_q;
  logic [TW-1:0]     timer_q;
  logic              ack;

  byte_sender u_sender (
    .clk100     (clk100),
    .rst_p      (rst_p),
    .ld_i       (ld_q),
    .byte_i     (ld_byte_q),
    .ack_o      (ack),
    .tx_ready_i (bus.tx_ready),
    .tx_byte_o  (bus.tx_byte),
    .tx_en_o    (bus.tx_en)
  );

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      last_q        <= '0;
      cmd_address_q <= '0;
      cmd_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      abort_seen_q  <= 1'b0;
      wait_ack_q    <= 1'b0;
      ld_q          <= 1'b0;
      idx_q         <= '0;
      ld_byte_q     <= 8'h00;
      shift_q       <= '0;
      timer_q       <= '0;
    end else begin
      done_q <= 1'b0;
      ld_q   <= 1'b0;
      // Abort only takes effect at the next word boundary (NEXT).
      if (busy_q && abort) abort_seen_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          last_q       <= last_addr;
          addr_q       <= '0;
          error_q      <= 1'b0;
          busy_q       <= 1'b1;
          abort_seen_q <= abort;
          idx_q        <= '0;
          wait_ack_q   <= 1'b0;
          state_q      <= HDR;
        end
        HDR: if (!wait_ack_q) begin
          ld_q       <= 1'b1;
          ld_byte_q  <= hdr_byte(idx_q, HDR0, HDR1, last_q);
          wait_ack_q <= 1'b1;
        end else if (ack) begin
          wait_ack_q <= 1'b0;
          if (idx_q == 3'(HDR_BYTES - 1)) begin
            cmd_enable_q  <= 1'b1;
            cmd_address_q <= addr_q;
            state_q       <= RD_REQ;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        // cmd_enable is already high on entry, so any cmd_ready here is an accept.
        RD_REQ: if (bus.cmd_ready) begin
          cmd_enable_q <= 1'b0;
          timer_q      <= '0;
          state_q      <= RD_WAIT;
        end
        RD_WAIT: if (bus.data_out_ready) begin
          shift_q <= bus.data_out;
          idx_q   <= '0;
          state_q <= TX_LOAD;
        end else if (timer_q == TMAX) begin
          error_q      <= 1'b1;
          cmd_enable_q <= 1'b0;
          state_q      <= FINISH;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
        // Data phase: hand the word to the sender MSB-first.
        TX_LOAD: if (!wait_ack_q) begin
          ld_q       <= 1'b1;
          ld_byte_q  <= shift_q[31:24];
          wait_ack_q <= 1'b1;
        end else if (ack) begin
          wait_ack_q <= 1'b0;
          shift_q    <= {shift_q[23:0], 8'h00};
          if (idx_q == 3'(WORD_BYTES - 1)) state_q <= NEXT;
          else                             idx_q   <= idx_q + 3'd1;
        end
        NEXT: if (addr_q == last_q || abort_seen_q || abort) begin
          state_q <= FINISH;
        end else begin
          addr_q        <= addr_q + 1'b1;
          cmd_address_q <= addr_q + 1'b1;
          cmd_enable_q  <= 1'b1;
          abort_seen_q  <= 1'b0;
          state_q       <= RD_REQ;
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_enable  = cmd_enable_q;
  assign bus.cmd_wr      = 1'b0;
  assign bus.cmd_address = cmd_address_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: doc/sample_dumper.md
SAMPLE_DUMPER -- requirements
Module: sample_dumper

Interface
REQ-001 SHALL have parameter HDR0, default 8'hA5, meaning first frame sync byte.
REQ-002 SHALL have parameter HDR1, default 8'h5A, meaning second frame sync byte.
REQ-003 SHALL have parameter RD_TIMEOUT, default 1023, meaning max cycles from read accept to data_out_ready.
REQ-004 SHALL have port clk100, input, 1, meaning 100 MHz system clock.
REQ-005 SHALL have port rst_p, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, meaning one-cycle dump request, honoured only in IDLE.
REQ-007 SHALL have port abort, input, 1, meaning stop dump at next word boundary.
REQ-008 SHALL have port last_addr, input, 23, meaning final word address to dump, sampled on start.
REQ-009 SHALL have port cmd_ready, input, 1, meaning SDRAM controller can accept a command.
REQ-010 SHALL have port cmd_enable, output, 1, meaning read command request.
REQ-011 SHALL have port cmd_wr, output, 1, meaning tied 0 (read only).
REQ-012 SHALL have port cmd_address, output, 23, meaning word address to read.
REQ-013 SHALL have port data_out, input, 32, meaning SDRAM read data.
REQ-014 SHALL have port data_out_ready, input, 1, meaning one-cycle read-data-valid pulse.
REQ-015 SHALL have port tx_byte, output, 8, meaning byte to UART.
REQ-016 SHALL have port tx_en, output, 1, meaning one-cycle UART send strobe.
REQ-017 SHALL have port tx_ready, input, 1, meaning UART idle.
REQ-018 SHALL have ports busy, done and error, each output, 1, meaning dump active, one-cycle completion pulse, and sticky read-timeout flag respectively.

Function
REQ-019 SHALL implement states IDLE, HDR, RD_REQ, RD_WAIT, TX_LOAD, TX_GUARD, TX_WAIT, NEXT and FINISH.
REQ-020 SHALL, on start in IDLE, latch last_addr, clear addr to 0, clear error, assert busy from the next cycle, and enter HDR.
REQ-021 SHALL, in HDR, send HDR0 then HDR1 then last_addr as 3 bytes MSB-first (upper byte zero-padded), using the TX handshake.
REQ-022 SHALL, for the TX handshake, drive tx_byte stable, pulse tx_en for exactly one cycle only when tx_ready=1, ignore tx_ready for one TX_GUARD cycle, then wait in TX_WAIT for tx_ready=1.
REQ-023 SHALL, in RD_REQ, hold cmd_enable=1 and cmd_address=addr until a cycle with cmd_ready=1, then drop cmd_enable on the next cycle and enter RD_WAIT.
REQ-024 SHALL, in RD_WAIT, capture data_out into a 32-bit shift register on data_out_ready and send it as 4 bytes MSB-first.
REQ-025 SHALL, if RD_TIMEOUT cycles elapse in RD_WAIT without data_out_ready, set error, deassert cmd_enable, and go to FINISH.
REQ-026 SHALL, in NEXT, go to FINISH if addr==latched last_addr or abort was seen since the last word; otherwise increment addr by 1 and go to RD_REQ.
REQ-027 SHALL latch an abort arriving mid-word and finish that word's 4 bytes before stopping, with no partial words.
REQ-028 SHALL handle last_addr=0 by sending exactly one word; last_addr=23'h7FFFFF SHALL dump 8388608 words with no addr wrap.
REQ-029 SHALL, in FINISH, pulse done for one cycle, drop busy, and return to IDLE.
REQ-030 SHALL ignore start while busy; start and abort together in IDLE SHALL start the dump and then stop after word 0.
REQ-031 SHALL make all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-032 SHALL, on rst_p (including mid-operation), force IDLE, cmd_enable=0, cmd_wr=0, cmd_address=0, tx_en=0, tx_byte=0, busy=0, done=0, error=0 and the counters to 0.
REQ-033 SHALL, after reset, emit no UART byte or SDRAM command until a new start.

Structure
REQ-034 SHALL place the state encodings, HDR0/HDR1 defaults and SDRAM_WORDS=8388608 in a shared constants package.
REQ-035 SHALL use one sub-module, byte_sender, owning the TX_LOAD/TX_GUARD/TX_WAIT handshake and presenting a load/ack interface to the main FSM.

Verification
REQ-036 SHALL cover: memory model with words 0x11223344 and 0xAABBCCDD, start with last_addr=1 -> UART bytes A5 5A 00 00 01 11 22 33 44 AA BB CC DD, then done pulse.
REQ-037 SHALL cover: cmd_ready held low 50 cycles -> cmd_enable held high with a stable address, and exactly one command accepted.
REQ-038 SHALL cover: data_out_ready withheld -> error=1 after 1023 cycles, done pulse, and no data bytes for that word.
REQ-039 SHALL cover: abort asserted during byte 2 of word 5, last_addr=100 -> words 0..5 complete (24 data bytes) and no further reads.
REQ-040 SHALL cover: tx_ready held low 10000 cycles -> no tx_en until it rises, and one tx_en per byte.
REQ-041 SHALL cover: rst_p asserted mid-word -> all outputs at reset values within one cycle, and a subsequent start produces the full header again.
